// File: rtl/keypad_pkg.sv
// Shared keypad types and key-code to row/column map (same table as keypad_decoder).
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, BOUNCE_IN, HELD, BOUNCE_OUT} kp_state_e;

  // Returns {row[1:0], col[1:0]} of the switch that produces the given hex code.
  function automatic logic [3:0] key_to_rc(input logic [3:0] code);
    logic [3:0] rc;
    case (code)
      4'h1:    rc = 4'b00_00;
      4'h2:    rc = 4'b00_01;
      4'h3:    rc = 4'b00_10;
      4'hA:    rc = 4'b00_11;
      4'h4:    rc = 4'b01_00;
      4'h5:    rc = 4'b01_01;
      4'h6:    rc = 4'b01_10;
      4'hB:    rc = 4'b01_11;
      4'h7:    rc = 4'b10_00;
      4'h8:    rc = 4'b10_01;
      4'h9:    rc = 4'b10_10;
      4'hC:    rc = 4'b10_11;
      4'hF:    rc = 4'b11_01;
      4'hE:    rc = 4'b11_10;
      4'hD:    rc = 4'b11_11;
      default: rc = 4'b11_00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keypad_emulator_ms_timer.sv
// One-ms tick generator plus loadable ms down-counter; load_ms is the duration minus one.
module ms_timer #(
  parameter int CYC_PER_MS = 125_000,
  parameter int MS_W       = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [MS_W-1:0] load_ms,
  output logic            expire,
  output logic            pre_expire
);

  localparam int CYC_W = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [CYC_W-1:0] CYC_LD = CYC_W'(CYC_PER_MS - 1);

  logic [CYC_W-1:0] cyc;
  logic [MS_W-1:0]  ms;

  // Holds at zero once expired so an idle timer never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= '0;
      ms  <= '0;
    end else if (load) begin
      cyc <= CYC_LD;
      ms  <= load_ms;
    end else if (cyc != '0) begin
      cyc <= cyc - 1'b1;
    end else if (ms != '0) begin
      ms  <= ms - 1'b1;
      cyc <= CYC_LD;
    end
  end

  assign expire     = (cyc == '0) && (ms == '0);
  assign pre_expire = (cyc == CYC_W'(1)) && (ms == '0);

endmodule

// File: rtl/keypad_emulator.sv
// PmodKYPD stand-in: presses one key for HOLD_MS, answering column strobes on the row lines.
// Optional contact bounce at press and release is built with KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int HOLD_MS  = 50
`ifdef KEYPAD_EMU_BOUNCE_EN
  ,
  parameter int BOUNCE_MS  = 2,
  parameter int BOUNCE_CYC = 64
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       press_req,
  output logic       busy,
  output logic       done,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       contact
);

  localparam int CYC_PER_MS = CLK_FREQ / 1000;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int MAX_MS = (HOLD_MS > BOUNCE_MS) ? HOLD_MS : BOUNCE_MS;
`else
  localparam int MAX_MS = HOLD_MS;
`endif
  localparam int MS_W = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;
  localparam logic [MS_W-1:0] HOLD_LD = MS_W'(HOLD_MS - 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [MS_W-1:0] BOUNCE_LD = MS_W'(BOUNCE_MS - 1);
  localparam int BC_W = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;
  localparam logic [BC_W-1:0] BC_LD = BC_W'(BOUNCE_CYC - 1);
  localparam kp_state_e FIRST_ST = BOUNCE_IN;
  localparam logic [MS_W-1:0] FIRST_LD = BOUNCE_LD;
`else
  localparam kp_state_e FIRST_ST = HELD;
  localparam logic [MS_W-1:0] FIRST_LD = HOLD_LD;
`endif

  kp_state_e       state;
  logic [3:0]      key_q;
  logic [3:0]      col_s1, col_sync;
  logic [1:0]      key_row, key_col;
  logic            load, expire, pre_expire;
  logic [MS_W-1:0] load_ms;

  assign {key_row, key_col} = key_to_rc(key_q);

  always_comb begin
    load    = 1'b0;
    load_ms = HOLD_LD;
    if (state == IDLE && press_req) begin
      load    = 1'b1;
      load_ms = FIRST_LD;
    end
`ifdef KEYPAD_EMU_BOUNCE_EN
    else if (state == BOUNCE_IN && expire) begin
      load = 1'b1;
    end else if (state == HELD && expire) begin
      load    = 1'b1;
      load_ms = BOUNCE_LD;
    end
`endif
  end

  ms_timer #(
    .CYC_PER_MS(CYC_PER_MS),
    .MS_W      (MS_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_ms   (load_ms),
    .expire    (expire),
    .pre_expire(pre_expire)
  );

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [BC_W-1:0] bcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    bcnt <= '0;
    else if (load || bcnt == '0) bcnt <= BC_LD;
    else                        bcnt <= bcnt - 1'b1;
  end
`endif

  // done is raised during the last busy cycle, so a request alongside it still sees busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      key_q   <= 4'h0;
      busy    <= 1'b0;
      done    <= 1'b0;
      contact <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (press_req) begin
          key_q   <= key_code;
          busy    <= 1'b1;
          contact <= 1'b1;
          state   <= FIRST_ST;
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        BOUNCE_IN: begin
          if (expire) begin
            contact <= 1'b1;
            state   <= HELD;
          end else if (bcnt == '0) begin
            contact <= ~contact;
          end
        end
        HELD: if (expire) begin
          contact <= 1'b0;
          state   <= BOUNCE_OUT;
        end
        BOUNCE_OUT: begin
          if (pre_expire) done <= 1'b1;
          if (expire) begin
            contact <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (bcnt == '0) begin
            contact <= ~contact;
          end
        end
`else
        HELD: begin
          if (pre_expire) done <= 1'b1;
          if (expire) begin
            contact <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Only the latched key's column is looked at, whatever else the scanner pulls low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1   <= 4'hF;
      col_sync <= 4'hF;
      row_n    <= 4'hF;
    end else begin
      col_s1   <= col_n;
      col_sync <= col_s1;
      row_n    <= (contact && !col_sync[key_col]) ? ~(4'b0001 << key_row) : 4'hF;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: random presses, reference scanner, busy-length model.
`timescale 1ns/1ps
module tb_keypad_emulator;

  localparam int CLK_FREQ = 10_000;
  localparam int HOLD_MS  = 5;
  localparam int CPM      = CLK_FREQ / 1000;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BMS      = 1;
  localparam int BCYC     = 2;
  localparam int BUSY_LEN = (HOLD_MS + 2 * BMS) * CPM;
`else
  localparam int BUSY_LEN = HOLD_MS * CPM;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_code = 4'h0;
  logic       press_req = 1'b0;
  logic       busy, done, contact;
  logic [3:0] col_n = 4'hF;
  logic [3:0] row_n;

  keypad_emulator #(
    .CLK_FREQ(CLK_FREQ),
    .HOLD_MS (HOLD_MS)
`ifdef KEYPAD_EMU_BOUNCE_EN
    ,
    .BOUNCE_MS (BMS),
    .BOUNCE_CYC(BCYC)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_code (key_code),
    .press_req(press_req),
    .busy     (busy),
    .done     (done),
    .col_n    (col_n),
    .row_n    (row_n),
    .contact  (contact)
  );

  always #5 clk = ~clk;

  typedef struct {
    int key;
    bit chk_scan;
  } exp_t;

  int   keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};
  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, free_at = 0, done_cnt = 0;
  int   seen_key = -1, seen_cnt = 0;
  bit   seen_bad = 0;
  bit   scan_en = 1;
  logic [3:0] col_force = 4'hF;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Issue a request at a negedge; the model accepts it if the DUT should be free by the next edge.
  task automatic press(input int k, input bit chk_scan);
    int   t;
    exp_t e;
    t         = cyc + 1;
    key_code  = 4'(k);
    press_req = 1'b1;
    if (t >= free_at) begin
      free_at    = t + BUSY_LEN + 1;
      e.key      = k;
      e.chk_scan = chk_scan;
      exp_q.push_back(e);
      seen_cnt = 0;
      seen_bad = 0;
      seen_key = -1;
    end
    @(negedge clk);
    press_req = 1'b0;
  endtask

  task automatic wait_free();
    while (cyc + 1 < free_at) @(negedge clk);
  endtask

  // Reference scanner: strobe each column, decode a closed switch from the row lines.
  initial begin : scanner
    logic [3:0] one;
    one = 4'b0001;
    forever begin
      if (!scan_en) begin
        col_n = col_force;
        @(negedge clk);
      end else begin
        for (int c = 0; c < 4; c++) begin
          col_n = ~(one << c);
          repeat (8) @(negedge clk);
          if (!rst && contact && row_n != 4'hF) begin
            int r, nz;
            r  = 0;
            nz = 0;
            for (int i = 0; i < 4; i++) if (!row_n[i]) begin r = i; nz++; end
            if (nz != 1) seen_bad = 1;
            else begin
              if (seen_cnt == 0) seen_key = keymap[r][c];
              else if (keymap[r][c] != seen_key) seen_bad = 1;
              seen_cnt++;
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    int   blen;
    bit   after_done;
    exp_t e;
    blen = 0;
    after_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        blen = 0;
        after_done = 0;
        continue;
      end
      if (after_done) begin
        check("busy_fall_after_done", busy, 0);
        after_done = 0;
      end
      if (busy) blen++;
      if (done) begin
        done_cnt++;
        check("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("busy_len", blen, BUSY_LEN);
          if (e.chk_scan) begin
            check("scan_hits", (seen_cnt > 0) && !seen_bad, 1);
            check("decoded_key", seen_key, e.key);
          end
        end
        after_done = 1;
      end
      if (!busy) blen = 0;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int perm[16];
    int base;
    repeat (3) @(negedge clk);
    check("rst_row_n", row_n, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_contact", contact, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);

    // basic press of key 5 under a cycling scanner
    press(5, 1);
    wait_free();
    repeat (3) @(negedge clk);

    // map sweep in shuffled order
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 16; i++) begin
      press(perm[i], 1);
      wait_free();
      repeat ($urandom_range(5, 1)) @(negedge clk);
    end

    // request while busy, then one coincident with done, then one just after
    press(1, 1);
    repeat (20) @(negedge clk);
    press(10, 1);
    while (cyc + 1 < free_at - 1) @(negedge clk);
    check("done_coincident", done, 1);
    press(7, 1);
    press(7, 1);
    wait_free();
    repeat (3) @(negedge clk);

    // random presses, sometimes with a rejected request mid-press
    for (int n = 0; n < 8; n++) begin
      press(int'($urandom_range(15, 0)), 1);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(BUSY_LEN - 2, 1)) @(negedge clk);
        press(int'($urandom_range(15, 0)), 1);
      end
      wait_free();
      repeat ($urandom_range(8, 1)) @(negedge clk);
    end

    // all columns low at once
    scan_en   = 0;
    col_force = 4'h0;
    repeat (40) @(negedge clk);
    press(14, 0);
    repeat (25) @(negedge clk);
    check("multi_col_key_e", row_n, 4'b0111);
    wait_free();
    repeat (3) @(negedge clk);
    press(2, 0);
    repeat (25) @(negedge clk);
    check("multi_col_key_2", row_n, 4'b1110);
    wait_free();
    scan_en = 1;
    repeat (3) @(negedge clk);

`ifdef KEYPAD_EMU_BOUNCE_EN
    begin
      logic prev;
      int   tg;
      tg   = 0;
      prev = contact;
      press(3, 1);
      for (int i = 0; i < 10; i++) begin
        if (contact !== prev) tg++;
        prev = contact;
        @(negedge clk);
      end
      check("bounce_toggles", tg, 5);
      check("held_contact", contact, 1);
      wait_free();
      repeat (3) @(negedge clk);
    end
`endif

    // reset in the middle of a held press
    press(9, 1);
    repeat (25) @(negedge clk);
    base = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("midpress_rst_row_n", row_n, 4'hF);
    check("midpress_rst_busy", busy, 0);
    check("midpress_rst_contact", contact, 0);
    exp_q.delete();
    free_at = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (BUSY_LEN + 10) @(negedge clk);
    check("no_done_after_rst", done_cnt, base);
    check("row_idle_after_rst", row_n, 4'hF);

    // a press still works after the reset
    press(13, 1);
    wait_free();
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
